// File: rtl/clk_div_bank_if.sv
// Divisor configuration port of the clock divider bank: valid/ready write
// handshake carrying a channel select and a new divisor value.
interface clk_div_bank_if #(
    parameter int NCH = 4,
    parameter int DW  = 16
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic          cfg_valid;
    logic          cfg_ready;
    logic [SW-1:0] cfg_sel;
    logic [DW-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_sel,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_sel,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider. Each channel walks a phase
// counter 0..N-1 and drives a registered ~50% duty clock plus a tick on the
// first cycle of every period. New divisors wait as pending until the
// running period ends, so a period is never cut short or stretched.
module clk_div_bank #(
    parameter int NCH         = 4,
    parameter int DW          = 16,
    parameter int DEFAULT_DIV = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    clk_div_bank_if.slave  cfg,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [DW-1:0] phase_q [NCH];
    logic [DW-1:0] div_q   [NCH];
    logic [DW-1:0] pdiv_q  [NCH];
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] act_q;

    logic [DW-1:0] phase_nx [NCH];
    logic [DW-1:0] div_nx   [NCH];
    logic [DW-1:0] pdiv_nx  [NCH];
    logic [DW-1:0] hi       [NCH];
    logic [NCH-1:0] pend_nx;
    logic [NCH-1:0] apply;
    logic [NCH-1:0] clk_nx;
    logic [NCH-1:0] tick_nx;
    logic           wr_acc;

    // Ready reflects only the addressed channel's pending slot; indices past
    // the last channel are always accepted and then dropped.
    always_comb begin
        cfg.cfg_ready = 1'b1;
        if (int'(cfg.cfg_sel) < NCH)
            cfg.cfg_ready = ~pend_q[cfg.cfg_sel];
    end

    assign wr_acc = cfg.cfg_valid & cfg.cfg_ready;

    // Per-channel next phase, divisor hand-over and registered output values.
    // Priority: disable, then (re)start or sync, then stopped/N=1, then wrap.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            apply[i]    = 1'b0;
            phase_nx[i] = '0;
            div_nx[i]   = div_q[i];
            pdiv_nx[i]  = pdiv_q[i];
            if (!en[i])
                apply[i] = 1'b1;
            else if (!act_q[i] || sync)
                apply[i] = 1'b1;
            else if (div_q[i] <= DW'(1))
                apply[i] = 1'b1;
            else if (phase_q[i] == div_q[i] - DW'(1))
                apply[i] = 1'b1;
            else
                phase_nx[i] = phase_q[i] + DW'(1);

            if (apply[i] && pend_q[i])
                div_nx[i] = pdiv_q[i];

            // A write landing on the same edge as an apply becomes the next
            // pending value rather than being lost.
            pend_nx[i] = pend_q[i] & ~apply[i];
            if (wr_acc && (cfg.cfg_sel == SW'(i))) begin
                pend_nx[i] = 1'b1;
                pdiv_nx[i] = cfg.cfg_div;
            end

            hi[i]      = (div_nx[i] >> 1) + {{(DW-1){1'b0}}, div_nx[i][0]};
            clk_nx[i]  = en[i] && (div_nx[i] != '0) && (phase_nx[i] < hi[i]);
            tick_nx[i] = en[i] && (div_nx[i] != '0) && (phase_nx[i] == '0);
        end
    end

    // Channel state and registered outputs; reset discards pending writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                phase_q[i] <= '0;
                div_q[i]   <= DW'(DEFAULT_DIV);
                pdiv_q[i]  <= '0;
            end
            pend_q  <= '0;
            act_q   <= '0;
            clk_out <= '0;
            tick    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                phase_q[i] <= phase_nx[i];
                div_q[i]   <= div_nx[i];
                pdiv_q[i]  <= pdiv_nx[i];
            end
            pend_q  <= pend_nx;
            act_q   <= en;
            clk_out <= clk_nx;
            tick    <= tick_nx;
        end
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a vector table for the default /16 run,
// then hand-written sequences for divisor hand-over, N=1/N=0, sync, enable
// toggling and reset with a pending write.
module tb_clk_div_bank;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en;
    logic       sync;
    logic [3:0] clk_out;
    logic [3:0] tick;

    int errs   = 0;
    int checks = 0;

    clk_div_bank_if #(.NCH(4), .DW(16)) cfg_if ();

    clk_div_bank #(.NCH(4), .DW(16), .DEFAULT_DIV(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .cfg     (cfg_if),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en;
        logic       sync;
        logic [3:0] exp_clk;
        logic [3:0] exp_tick;
        logic       exp_rdy;
    } vec_t;

    vec_t tbl [38];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] ec, input logic [3:0] et, input logic er);
        checks++;
        if (clk_out !== ec || tick !== et || cfg_if.cfg_ready !== er) begin
            errs++;
            $display("FAIL %s: got clk_out=%b tick=%b ready=%b, want clk_out=%b tick=%b ready=%b",
                     nm, clk_out, tick, cfg_if.cfg_ready, ec, et, er);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want completion");
        $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic c0, c1, t0, t1;
        rst = 1'b0;
        en = 4'b0001;
        sync = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_sel = 2'd0;
        cfg_if.cfg_div = 16'd0;

        for (int k = 0; k < 38; k++)
            tbl[k] = '{4'b0001, 1'b0, {3'b000, (k % 16) < 8}, {3'b000, (k % 16) == 0}, 1'b1};

        // reset state, with en already high
        step();
        step();
        chk("reset", 4'b0000, 4'b0000, 1'b1);
        rst = 1'b1;

        // default /16 on channel 0
        for (int k = 0; k < 38; k++) begin
            en = tbl[k].en;
            sync = tbl[k].sync;
            step();
            chk($sformatf("t1_k%0d", k), tbl[k].exp_clk, tbl[k].exp_tick, tbl[k].exp_rdy);
        end

        // write N=5 at p=5; applies only at the wrap after p=15
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_sel = 2'd0;
        cfg_if.cfg_div = 16'd5;
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("t2_accept", 4'b0001, 4'b0000, 1'b0);
        for (int p = 7; p < 16; p++) begin
            step();
            chk($sformatf("t2_old_p%0d", p), {3'b000, p < 8}, 4'b0000, 1'b0);
        end
        step();
        chk("t2_wrap", 4'b0001, 4'b0001, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("t2_n5_k%0d", k), {3'b000, (k % 5) < 3}, {3'b000, (k % 5) == 0}, 1'b1);
        end

        // N=1 then N=0 on channel 1
        en = 4'b0000;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_sel = 2'd1;
        cfg_if.cfg_div = 16'd1;
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("t3_wr1", 4'b0000, 4'b0000, 1'b0);
        step();
        chk("t3_apply_off", 4'b0000, 4'b0000, 1'b1);
        en = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t3_n1_k%0d", k), 4'b0010, 4'b0010, 1'b1);
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 16'd0;
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("t3_wr0", 4'b0010, 4'b0010, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t3_n0_k%0d", k), 4'b0000, 4'b0000, 1'b1);
        end

        // ch0 N=16, ch1 N=10, then sync
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_sel = 2'd0;
        cfg_if.cfg_div = 16'd16;
        step();
        chk("t4_wr_ch0", 4'b0000, 4'b0000, 1'b0);
        cfg_if.cfg_sel = 2'd1;
        cfg_if.cfg_div = 16'd10;
        step();
        chk("t4_wr_ch1", 4'b0000, 4'b0000, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        step();
        chk("t4_ch1_start", 4'b0010, 4'b0010, 1'b1);
        en = 4'b0011;
        step();
        chk("t4_ch0_start", 4'b0011, 4'b0001, 1'b1);
        repeat (4) step();
        chk("t4_pre_sync", 4'b0001, 4'b0000, 1'b1);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("t4_sync", 4'b0011, 4'b0011, 1'b1);
        for (int k = 1; k < 40; k++) begin
            step();
            c0 = (k % 16) < 8;
            c1 = (k % 10) < 5;
            t0 = (k % 16) == 0;
            t1 = (k % 10) == 0;
            chk($sformatf("t4_k%0d", k), {2'b00, c1, c0}, {2'b00, t1, t0}, 1'b1);
        end

        // en[2] dropped at p=3 and restored five cycles later
        en = 4'b0100;
        step();
        chk("t5_start", 4'b0100, 4'b0100, 1'b1);
        repeat (3) step();
        chk("t5_p3", 4'b0100, 4'b0000, 1'b1);
        en = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t5_off_k%0d", k), 4'b0000, 4'b0000, 1'b1);
        end
        en = 4'b0100;
        step();
        chk("t5_back", 4'b0100, 4'b0100, 1'b1);
        step();
        chk("t5_back_p1", 4'b0100, 4'b0000, 1'b1);

        // reset at p=7 with a pending write on channel 2
        repeat (4) step();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_sel = 2'd2;
        cfg_if.cfg_div = 16'd4;
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("t6_pend_p6", 4'b0100, 4'b0000, 1'b0);
        step();
        chk("t6_pend_p7", 4'b0100, 4'b0000, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async", 4'b0000, 4'b0000, 1'b1);
        step();
        rst = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step();
            chk($sformatf("t6_after_k%0d", k), {1'b0, (k % 16) < 8, 2'b00},
                {1'b0, (k % 16) == 0, 2'b00}, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
